// File: rtl/ip_v4_crc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ip_v4_crc_pkg
// Brief   : Shared widths and FSM state type for the checksum-engine arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package ip_v4_crc_pkg;

    localparam int WORD_W = 32;
    localparam int CRC_W  = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        STREAM = 3'd2,
        WAIT   = 3'd3,
        RESP   = 3'd4
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/ip_v4_crc_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick of the first request after ptr.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         gnt_oh,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     any
);

    localparam int ID_W = $clog2(N_REQ);

    int w_idx;

    // Scan from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        w_idx   = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = (int'(ptr) + k) % N_REQ;
            if (req[w_idx]) begin
                gnt_oh        = '0;
                gnt_oh[w_idx] = 1'b1;
                gnt_idx       = ID_W'(w_idx);
                any           = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ip_v4_crc_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ip_v4_crc_arbiter
// Brief   : Round-robin sharing of one header checksum engine between N_REQ
//           sources, returning {id, crc, err} on a valid/ready port.
// Revision: 1.0 - initial release
// ============================================================================
module ip_v4_crc_arbiter
    import ip_v4_crc_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_vld,
    input  logic [N_REQ*WORD_W-1:0]  req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_rdy,
    output logic                     eng_start,
    output logic [WORD_W-1:0]        eng_d_in,
    output logic                     eng_d_in_vld,
    input  logic [CRC_W-1:0]         eng_crc,
    input  logic                     eng_crc_vld,
    output logic                     rsp_vld,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [CRC_W-1:0]         rsp_crc,
    output logic                     rsp_err,
    input  logic                     rsp_rdy
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] C_TO_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t       r_state, w_state_nxt;
    logic [ID_W-1:0]  r_gnt, r_rr_ptr, w_gnt_idx;
    logic [N_REQ-1:0] r_gnt_oh, w_gnt_oh;
    logic             w_any;
    logic             r_crc_seen;
    logic [CNT_W-1:0] r_to_cnt;
    logic [CRC_W-1:0] r_rsp_crc;
    logic             r_rsp_err;
    logic             w_vld_g, w_last_g, w_crc_take, w_timeout;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req     (req_vld),
        .ptr     (r_rr_ptr),
        .gnt_oh  (w_gnt_oh),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    assign w_vld_g    = req_vld[r_gnt];
    assign w_last_g   = req_last[r_gnt];
    // First checksum pulse of the packet only; pulses outside STREAM/WAIT are stale.
    assign w_crc_take = eng_crc_vld && !r_crc_seen && (r_state == STREAM || r_state == WAIT);
    assign w_timeout  = (r_state == WAIT) && !r_crc_seen && !eng_crc_vld && (r_to_cnt == C_TO_LAST);

    assign rsp_id  = r_gnt;
    assign rsp_crc = r_rsp_crc;
    assign rsp_err = r_rsp_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        req_rdy      = '0;
        eng_start    = 1'b0;
        eng_d_in     = '0;
        eng_d_in_vld = 1'b0;
        rsp_vld      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) w_state_nxt = START;
            end
            START: begin
                eng_start   = 1'b1;
                w_state_nxt = STREAM;
            end
            STREAM: begin
                req_rdy      = r_gnt_oh;
                eng_d_in     = req_data[WORD_W*r_gnt +: WORD_W];
                eng_d_in_vld = w_vld_g;
                if (w_vld_g && w_last_g) w_state_nxt = r_crc_seen ? RESP : WAIT;
            end
            WAIT: begin
                if (r_crc_seen || eng_crc_vld || w_timeout) w_state_nxt = RESP;
            end
            RESP: begin
                rsp_vld = 1'b1;
                if (rsp_rdy) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt      <= '0;
            r_gnt_oh   <= '0;
            r_rr_ptr   <= ID_W'(N_REQ - 1);
            r_crc_seen <= 1'b0;
            r_to_cnt   <= '0;
            r_rsp_crc  <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_gnt    <= w_gnt_idx;
                r_gnt_oh <= w_gnt_oh;
            end
            if (r_state == START) begin
                r_crc_seen <= 1'b0;
                r_rsp_crc  <= '0;
                r_rsp_err  <= 1'b0;
            end
            if (w_crc_take) begin
                r_rsp_crc  <= eng_crc;
                r_crc_seen <= 1'b1;
            end
            r_to_cnt <= (r_state == WAIT) ? r_to_cnt + 1'b1 : '0;
            if (w_timeout) begin
                r_rsp_err <= 1'b1;
                r_rsp_crc <= '0;
            end
            if (r_state == RESP && rsp_rdy) r_rr_ptr <= r_gnt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ip_v4_crc_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ip_v4_crc_arbiter
// Brief   : Scoreboard bench with a behavioural IPv4 header checksum engine.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ip_v4_crc_arbiter;

    localparam int N   = 4;
    localparam int TO  = 16;
    localparam int IDW = 2;

    typedef struct packed {
        logic [3:0]       id;
        logic [15:0]      crc;
        logic             err;
        logic [4:0][31:0] w;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req_vld = '0;
    logic [N-1:0]   req_last = '0;
    logic [N*32-1:0] req_data = '0;
    logic [N-1:0]   req_rdy;
    logic           eng_start, eng_d_in_vld, rsp_vld, rsp_err;
    logic [31:0]    eng_d_in;
    logic [15:0]    eng_crc = '0;
    logic           eng_crc_vld = 1'b0;
    logic [IDW-1:0] rsp_id;
    logic [15:0]    rsp_crc;
    logic           rsp_rdy = 1'b1;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          start_cnt = 0;
    int          inj_req = 0;
    int          mptr = N - 1;
    bit          bubbles = 1'b0;
    logic [15:0] eng_pulse_val = '0;
    logic [31:0] pbuf [$];
    logic [31:0] wq [N][$];
    int          lq [N][$];
    exp_t        mexp [N][$];
    exp_t        exp_q [$];
    int          served [$];

    ip_v4_crc_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .req_vld      (req_vld),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_rdy      (req_rdy),
        .eng_start    (eng_start),
        .eng_d_in     (eng_d_in),
        .eng_d_in_vld (eng_d_in_vld),
        .eng_crc      (eng_crc),
        .eng_crc_vld  (eng_crc_vld),
        .rsp_vld      (rsp_vld),
        .rsp_id       (rsp_id),
        .rsp_crc      (rsp_crc),
        .rsp_err      (rsp_err),
        .rsp_rdy      (rsp_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (eng_start) start_cnt <= start_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] fold(input int unsigned s);
        int unsigned t;
        t = s;
        while (t > 32'hFFFF) t = (t & 32'hFFFF) + (t >> 16);
        return 16'(t);
    endfunction

    // Ones-complement sum of a 5-word header with ck in the checksum field.
    function automatic logic [15:0] hdr_sum(input logic [4:0][31:0] w, input logic [15:0] ck);
        int unsigned s;
        s = 0;
        for (int i = 0; i < 5; i++) begin
            s += {16'h0, w[i][31:16]};
            s += (i == 2) ? {16'h0, ck} : {16'h0, w[i][15:0]};
        end
        return fold(s);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Stand-in engine: IHL from word 0, checksum over IHL words, pulse after the last.
    initial begin : p_engine
        bit          s, v, act;
        logic [31:0] d;
        int          ecnt, ihl, inj_seen;
        int unsigned esum;
        act = 0; ecnt = 0; ihl = 0; esum = 0; inj_seen = 0;
        forever begin
            @(negedge clk);
            s = eng_start; v = eng_d_in_vld; d = eng_d_in;
            @(posedge clk); #1;
            eng_crc_vld = 1'b0;
            if (!rst_n) begin
                act = 0; ecnt = 0; esum = 0;
            end else if (s) begin
                act = 1; ecnt = 0; esum = 0;
            end else if (v && act) begin
                if (ecnt == 0) ihl = int'(d[27:24]);
                if (ecnt < ihl) begin
                    esum += {16'h0, d[31:16]};
                    if (ecnt != 2) esum += {16'h0, d[15:0]};
                end
                ecnt++;
                if (ecnt == ihl) begin
                    eng_crc       = ~fold(esum);
                    eng_crc_vld   = 1'b1;
                    eng_pulse_val = eng_crc;
                    act           = 0;
                end
            end
            if (inj_req != inj_seen) begin
                inj_seen    = inj_req;
                eng_crc     = 16'h5A5A;
                eng_crc_vld = 1'b1;
            end
        end
    end

    initial begin : p_drv
        bit acc [N];
        int dcnt [N];
        for (int i = 0; i < N; i++) dcnt[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) acc[i] = req_vld[i] & req_rdy[i];
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (!rst_n) begin
                    wq[i].delete(); lq[i].delete(); dcnt[i] = 0;
                end else if (acc[i] && lq[i].size() > 0) begin
                    void'(wq[i].pop_front());
                    dcnt[i]++;
                    if (dcnt[i] == lq[i][0]) begin
                        void'(lq[i].pop_front());
                        dcnt[i] = 0;
                    end
                end
                if (lq[i].size() > 0) begin
                    req_data[32*i +: 32] = wq[i][0];
                    req_last[i] = (dcnt[i] == lq[i][0] - 1);
                    req_vld[i]  = !(bubbles && dcnt[i] > 0 && $urandom_range(3) == 0);
                end else begin
                    req_vld[i]  = 1'b0;
                    req_last[i] = 1'b0;
                end
            end
        end
    end

    initial begin : p_mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_vld && rsp_rdy) begin
                served.push_back(int'(rsp_id));
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp actual id=%0d crc=%0h required no response", rsp_id, rsp_crc);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    chk("rsp_crc", 32'(rsp_crc), 32'(e.crc));
                    if (!e.err) chk("rsp_onesum", 32'(hdr_sum(e.w, rsp_crc)), 32'hFFFF);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic gen(input int n);
        pbuf.delete();
        for (int i = 0; i < n; i++) pbuf.push_back($urandom);
        pbuf[0] = {8'h45, 24'($urandom)};
    endtask

    task automatic add_pkt(input int r);
        exp_t e;
        e = '0;
        e.id = 4'(r);
        foreach (pbuf[i]) wq[r].push_back(pbuf[i]);
        lq[r].push_back(pbuf.size());
        if (pbuf.size() < 5) begin
            e.err = 1'b1;
        end else begin
            for (int i = 0; i < 5; i++) e.w[i] = pbuf[i];
            e.crc = ~hdr_sum(e.w, 16'h0);
        end
        mexp[r].push_back(e);
    endtask

    // Serve pending packets in round-robin order starting after mptr.
    task automatic run_model();
        int idx;
        bit found;
        found = 1;
        while (found) begin
            found = 0;
            idx = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && mexp[(mptr + k) % N].size() > 0) begin
                    idx = (mptr + k) % N;
                    found = 1;
                end
            end
            if (found) begin
                exp_q.push_back(mexp[idx].pop_front());
                mptr = idx;
            end
        end
    endtask

    task automatic wait_idle();
        int c;
        bit busy;
        c = 0;
        busy = 1;
        while (busy && c < 5000) begin
            @(negedge clk);
            c++;
            busy = (exp_q.size() > 0);
            for (int i = 0; i < N; i++) if (lq[i].size() > 0) busy = 1;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL wait_idle actual pending=%0d required 0 within 5000 cycles", exp_q.size());
        end
        step(); step();
    endtask

    task automatic measure(output int t0, output int t1);
        t0 = -1; t1 = -1;
        for (int c = 0; c < 3000 && t1 < 0; c++) begin
            @(negedge clk);
            if (|(req_vld & req_rdy & req_last)) t0 = cyc + 1;
            if (rsp_vld) t1 = cyc;
        end
        if (t1 < 0) begin
            checks++; errors++;
            $display("FAIL measure actual no rsp_vld required rsp_vld within 3000 cycles");
        end
    endtask

    task automatic hit_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        exp_q.delete();
        mptr = N - 1;
        for (int i = 0; i < N; i++) mexp[i].delete();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_req_rdy"}, 32'(req_rdy), 0);
        chk({tag, "_eng_start"}, 32'(eng_start), 0);
        chk({tag, "_eng_d_in_vld"}, 32'(eng_d_in_vld), 0);
        chk({tag, "_eng_d_in"}, eng_d_in, 0);
        chk({tag, "_rsp_vld"}, 32'(rsp_vld), 0);
        chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
        chk({tag, "_rsp_crc"}, 32'(rsp_crc), 0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
    endtask

    initial begin : p_main
        int t0, t1, base, s0, nv, c;
        logic [IDW-1:0] id0;
        logic [15:0] crc0;
        logic err0;
        bit stable;
        int ord2 [5];
        ord2 = '{0, 1, 2, 3, 0};

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_outputs_zero("reset");
        @(posedge clk); #2 rst_n = 1'b1;

        // Gold header on req 0
        s0 = start_cnt;
        pbuf = '{32'h4500_0073, 32'h0000_4000, 32'h4011_b861, 32'hc0a8_0001,
                 32'hc0a8_00c7, 32'h0000_0000, 32'hdead_beef, 32'h1234_5678};
        add_pkt(0);
        run_model();
        wait_idle();
        chk("t1_start_pulses", start_cnt - s0, 1);

        // All four request together
        hit_reset();
        release_reset();
        base = served.size();
        gen(8); add_pkt(0);
        for (int r = 1; r < N; r++) begin gen($urandom_range(5, 12)); add_pkt(r); end
        gen($urandom_range(5, 12)); add_pkt(0);
        run_model();
        wait_idle();
        chk("t2_count", served.size() - base, 5);
        for (int k = 0; k < 5; k++)
            if (base + k < served.size()) chk("t2_order", served[base + k], ord2[k]);

        // Pointer at 1, only 0 and 3 requesting
        gen(6); add_pkt(1); run_model(); wait_idle();
        base = served.size();
        gen(7); add_pkt(0);
        gen(5); add_pkt(3);
        run_model();
        wait_idle();
        chk("t3_count", served.size() - base, 2);
        if (base + 1 < served.size()) begin
            chk("t3_first", served[base], 3);
            chk("t3_second", served[base + 1], 0);
        end

        // Long packet, checksum arrives mid-stream
        bubbles = 1'b1;
        gen(600); add_pkt(2); run_model();
        measure(t0, t1);
        chk("t4_direct_resp", t1 - t0, 0);
        chk("t4_crc_pulse", 32'(rsp_crc), 32'(eng_pulse_val));
        wait_idle();
        bubbles = 1'b0;

        // Short packet, engine never answers
        step(); rsp_rdy = 1'b0;
        gen(2); add_pkt(3); run_model();
        measure(t0, t1);
        chk("t5_timeout_latency", t1 - t0, TO);
        inj_req++;
        repeat (3) step();
        chk("t5_rsp_vld_held", 32'(rsp_vld), 1);
        chk("t5_crc_zero", 32'(rsp_crc), 0);
        chk("t5_err", 32'(rsp_err), 1);
        rsp_rdy = 1'b1;
        wait_idle();
        inj_req++;
        nv = 0;
        repeat (10) begin @(negedge clk); if (rsp_vld) nv++; end
        chk("t5_no_second_rsp", nv, 0);

        // Stalled response, then reset mid-stream
        step(); rsp_rdy = 1'b0;
        gen(6); add_pkt(2); run_model();
        c = 0;
        while (!rsp_vld && c < 500) begin @(negedge clk); c++; end
        chk("t6_rsp_seen", 32'(rsp_vld), 1);
        id0 = rsp_id; crc0 = rsp_crc; err0 = rsp_err;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!rsp_vld || rsp_id !== id0 || rsp_crc !== crc0 || rsp_err !== err0) stable = 1'b0;
        end
        chk("t6_stall_stable", 32'(stable), 1);
        step(); rsp_rdy = 1'b1;
        wait_idle();

        bubbles = 1'b1;
        gen(100); add_pkt(1); run_model();
        c = 0;
        while (!eng_d_in_vld && c < 500) begin @(negedge clk); c++; end
        chk("t6_in_stream", 32'(eng_d_in_vld), 1);
        repeat (5) step();
        hit_reset();
        #1 chk_outputs_zero("t6_midreset");
        release_reset();
        bubbles = 1'b0;
        step();
        base = served.size();
        gen(5); add_pkt(2);
        gen(9); add_pkt(0);
        run_model();
        wait_idle();
        chk("t6_post_count", served.size() - base, 2);
        if (base < served.size()) chk("t6_first_after_reset", served[base], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
